// File: rtl/gf163_digit_mul_ctrl.sv
// gf163_digit_mul_ctrl
// Sequencer for a digit-serial GF(2^163) multiplier datapath. On start it
// latches A (held on o_a_out for the whole operation) and B (into a zero-padded
// shift register), streams B most significant digit first, one digit per
// cycle, with matching accumulator clear/enable strobes. It then waits out the
// datapath pipeline, captures the reduced product and pulses o_done.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   i_start          multiply request, sampled only when idle
//   i_abort          cancel the in-flight multiply, ignored when idle
//   i_a_in, i_b_in   operands, sampled when start is accepted
//   o_a_out          registered A for the datapath
//   o_b_digit_out    current B digit for the PE array
//   o_acc_clr        accumulator treats its previous value as zero
//   o_acc_en         accumulator updates this cycle
//   i_dp_result_in   reduced product from the datapath
//   o_result_out     captured product, held until the next completion
//   o_busy           operation in progress (RUN or FLUSH)
//   o_done           one-cycle completion pulse
//
// State | meaning
// IDLE  | waiting for start; done may be high in the first IDLE cycle
// RUN   | one digit per cycle, NDIG cycles
// FLUSH | acc idle, waiting PIPE cycles for the datapath result
module gf163_digit_mul_ctrl #(
  parameter int M      = 163,
  parameter int DIGITS = 16,
  parameter int NDIG   = 11,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [M-1:0]      i_a_in,
  input  logic [M-1:0]      i_b_in,
  output logic [M-1:0]      o_a_out,
  output logic [DIGITS-1:0] o_b_digit_out,
  output logic              o_acc_clr,
  output logic              o_acc_en,
  input  logic [M-1:0]      i_dp_result_in,
  output logic [M-1:0]      o_result_out,
  output logic              o_busy,
  output logic              o_done
);

  localparam int SRW = NDIG * DIGITS;
  localparam int DCW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FCW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [SRW-1:0]  r_b_sr;
  logic [DCW-1:0]  r_dcnt;
  logic [FCW-1:0]  r_fcnt;

  logic [SRW-1:0]  w_b_load;
  logic [SRW-1:0]  w_b_shift;

  // B is zero-extended so the pad sits in the top (most significant) digit.
  assign w_b_load  = SRW'(i_b_in);
  assign w_b_shift = r_b_sr << DIGITS;

  // The digit/strobe registers are loaded with the value they must present
  // in the cycle after the edge, so each digit appears together with its
  // acc_en and the top of r_b_sr always matches o_b_digit_out in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_b_sr        <= '0;
      r_dcnt        <= '0;
      r_fcnt        <= '0;
      o_a_out       <= '0;
      o_b_digit_out <= '0;
      o_acc_clr     <= 1'b0;
      o_acc_en      <= 1'b0;
      o_result_out  <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // start wins over abort here; abort only matters while busy
          if (i_start) begin
            o_a_out       <= i_a_in;
            r_b_sr        <= w_b_load;
            o_b_digit_out <= w_b_load[SRW-1 -: DIGITS];
            o_acc_en      <= 1'b1;
            o_acc_clr     <= 1'b1;
            r_dcnt        <= DCW'(NDIG - 1);
            o_busy        <= 1'b1;
            r_state       <= S_RUN;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            o_b_digit_out <= '0;
            o_acc_en      <= 1'b0;
            o_acc_clr     <= 1'b0;
            o_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else if (r_dcnt == '0) begin
            r_b_sr        <= w_b_shift;
            o_b_digit_out <= '0;
            o_acc_en      <= 1'b0;
            o_acc_clr     <= 1'b0;
            r_fcnt        <= FCW'(PIPE - 1);
            r_state       <= S_FLUSH;
          end else begin
            r_b_sr        <= w_b_shift;
            o_b_digit_out <= w_b_shift[SRW-1 -: DIGITS];
            o_acc_clr     <= 1'b0;
            r_dcnt        <= r_dcnt - DCW'(1);
          end
        end

        S_FLUSH: begin
          // abort beats a completion landing on the same edge
          if (i_abort) begin
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_fcnt == '0) begin
            o_result_out <= i_dp_result_in;
            o_done       <= 1'b1;
            o_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - FCW'(1);
          end
        end

        default: begin
          o_b_digit_out <= '0;
          o_acc_en      <= 1'b0;
          o_acc_clr     <= 1'b0;
          o_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf163_digit_mul_ctrl.sv
// Bench for gf163_digit_mul_ctrl: a bit-serial behavioural datapath feeds
// dp_result_in; products are compared to a schoolbook multiply-then-reduce
// reference.
module tb_gf163_digit_mul_ctrl;

  localparam int M      = 163;
  localparam int DIGITS = 16;
  localparam int NDIG   = 11;
  localparam int PIPE   = 1;
  localparam int SRW    = NDIG * DIGITS;
  localparam int PW     = 2 * M - 1;
  localparam int LAT    = NDIG + PIPE + 1;

  localparam logic [M:0]   F_POLY = {1'b1, {(M-8){1'b0}}, 8'hC9};
  localparam logic [M-1:0] F_LOW  = {{(M-8){1'b0}}, 8'hC9};

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [M-1:0]      a_in;
  logic [M-1:0]      b_in;
  logic [M-1:0]      a_out;
  logic [DIGITS-1:0] b_digit_out;
  logic              acc_clr;
  logic              acc_en;
  logic [M-1:0]      dp_result_in;
  logic [M-1:0]      result_out;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_err = 0;
  logic [DIGITS-1:0] g_first_dig;
  logic [DIGITS-1:0] g_last_dig;

  gf163_digit_mul_ctrl #(.M(M), .DIGITS(DIGITS), .NDIG(NDIG), .PIPE(PIPE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_a_in         (a_in),
    .i_b_in         (b_in),
    .o_a_out        (a_out),
    .o_b_digit_out  (b_digit_out),
    .o_acc_clr      (acc_clr),
    .o_acc_en       (acc_en),
    .i_dp_result_in (dp_result_in),
    .o_result_out   (result_out),
    .o_busy         (busy),
    .o_done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: acc = acc*x^16 + A*digit (mod f), done bit by bit.
  function automatic logic [M-1:0] dp_step(input logic [M-1:0] prev,
                                           input logic [M-1:0] a,
                                           input logic [DIGITS-1:0] d);
    logic [M-1:0] acc;
    acc = prev;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      acc = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? F_LOW : '0) ^ (d[j] ? a : '0);
    end
    return acc;
  endfunction

  logic [M-1:0] dp_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_acc <= '0;
    else if (acc_en) dp_acc <= dp_step(acc_clr ? '0 : dp_acc, a_out, b_digit_out);
  end
  assign dp_result_in = dp_acc;

  // Reference: full polynomial product, then reduction by f.
  function automatic logic [M-1:0] gf_mul_ref(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++) if (b[i]) p = p ^ (PW'(a) << i);
    for (int i = PW - 1; i >= M; i--) if (p[i]) p = p ^ (PW'(F_POLY) << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rnd163();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[M-1:0];
  endfunction

  task automatic chk(input string tag, input logic [SRW-1:0] got, input logic [SRW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiply; optionally a second start with other operands is pulsed
  // at RUN cycle inj (0 = none), which must be ignored.
  task automatic do_mul(input logic [M-1:0] a, input logic [M-1:0] b, input string tag,
                        input int inj, input logic [M-1:0] a2, input logic [M-1:0] b2);
    logic [SRW-1:0] bp;
    int n_en, done_at, n_done, dig_err, clr_err, busy_err, aout_err;
    bp = SRW'(b);
    n_en = 0; done_at = 0; n_done = 0;
    dig_err = 0; clr_err = 0; busy_err = 0; aout_err = 0;
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= LAT + 3; cyc++) begin
      if (inj != 0 && cyc == inj) begin
        start = 1'b1; a_in = a2; b_in = b2;
      end
      if (inj != 0 && cyc == inj + 1) start = 1'b0;
      if (acc_en) begin
        if (n_en < NDIG) begin
          if (b_digit_out !== bp[SRW-1-DIGITS*n_en -: DIGITS]) dig_err++;
        end
        if (n_en == 0) g_first_dig = b_digit_out;
        g_last_dig = b_digit_out;
        if (acc_clr !== (n_en == 0)) clr_err++;
        n_en++;
      end else if (acc_clr) clr_err++;
      if (busy !== (cyc < LAT)) busy_err++;
      if (cyc < LAT && a_out !== a) aout_err++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = cyc;
      end
      tick();
    end
    chk({tag, "_acc_en_count"}, SRW'(n_en), SRW'(NDIG));
    chk({tag, "_digits"}, SRW'(dig_err), '0);
    chk({tag, "_acc_clr"}, SRW'(clr_err), '0);
    chk({tag, "_busy"}, SRW'(busy_err), '0);
    chk({tag, "_a_out_hold"}, SRW'(aout_err), '0);
    chk({tag, "_done_at"}, SRW'(done_at), SRW'(LAT));
    chk({tag, "_done_pulses"}, SRW'(n_done), SRW'(1));
    chk({tag, "_result"}, SRW'(result_out), SRW'(gf_mul_ref(a, b)));
  endtask

  initial begin
    logic [M-1:0] x162, xa, prev, ra, rb, ra2, rb2, r1, r2;
    int d1, d2, n_done, busy_bad;
    x162 = '0; x162[162] = 1'b1;
    xa = '0; xa[1] = 1'b1;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a_in = '0; b_in = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", SRW'(busy), '0);
    chk("rst_done", SRW'(done), '0);
    chk("rst_acc", SRW'({acc_en, acc_clr}), '0);
    chk("rst_digit", SRW'(b_digit_out), '0);
    chk("rst_a_out", SRW'(a_out), '0);
    chk("rst_result", SRW'(result_out), '0);
    rst_n = 1'b1;
    tick();

    // Digit order with b=1
    do_mul(M'(1), M'(1), "one", 0, '0, '0);
    chk("one_first_digit", SRW'(g_first_dig), '0);
    chk("one_last_digit", SRW'(g_last_dig), SRW'(1));
    chk("one_value", SRW'(result_out), SRW'(1));

    // Top digit with b=x^162
    ra = rnd163();
    do_mul(ra, x162, "top", 0, '0, '0);
    chk("top_first_digit", SRW'(g_first_dig), SRW'(4));
    chk("top_last_digit", SRW'(g_last_dig), '0);

    // x^162 * x = x^163 = x^7+x^6+x^3+1
    do_mul(x162, xa, "wrap", 0, '0, '0);
    chk("wrap_value", SRW'(result_out), SRW'(8'hC9));

    // Start pulsed in RUN cycle 5 is ignored
    ra = rnd163(); rb = rnd163(); ra2 = rnd163(); rb2 = rnd163();
    do_mul(ra, rb, "ign", 5, ra2, rb2);

    // Back-to-back with start held high
    ra = rnd163(); rb = rnd163(); ra2 = rnd163(); rb2 = rnd163();
    d1 = 0; d2 = 0; n_done = 0; r1 = '0; r2 = '0;
    a_in = ra; b_in = rb; start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 2 * LAT + 3; cyc++) begin
      if (done) begin
        n_done++;
        if (d1 == 0) begin d1 = cyc; r1 = result_out; end
        else if (d2 == 0) begin d2 = cyc; r2 = result_out; end
      end
      if (cyc == LAT) begin a_in = ra2; b_in = rb2; end
      if (cyc == LAT + 1) start = 1'b0;
      tick();
    end
    chk("b2b_done1_at", SRW'(d1), SRW'(LAT));
    chk("b2b_done2_at", SRW'(d2), SRW'(2 * LAT));
    chk("b2b_pulses", SRW'(n_done), SRW'(2));
    chk("b2b_result1", SRW'(r1), SRW'(gf_mul_ref(ra, rb)));
    chk("b2b_result2", SRW'(r2), SRW'(gf_mul_ref(ra2, rb2)));

    // Abort in RUN cycle 6
    prev = result_out;
    ra = rnd163(); rb = rnd163();
    n_done = 0; busy_bad = 0;
    a_in = ra; b_in = rb; start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= LAT + 5; cyc++) begin
      if (cyc == 6) abort = 1'b1;
      if (cyc == 7) begin
        abort = 1'b0;
        chk("abort_busy", SRW'(busy), '0);
        chk("abort_acc_en", SRW'(acc_en), '0);
      end
      if (cyc > 7 && busy) busy_bad++;
      if (done) n_done++;
      tick();
    end
    chk("abort_no_done", SRW'(n_done), '0);
    chk("abort_stays_idle", SRW'(busy_bad), '0);
    chk("abort_result_kept", SRW'(result_out), SRW'(prev));
    chk("abort_a_out_kept", SRW'(a_out), SRW'(ra));
    do_mul(rnd163(), rnd163(), "post_abort", 0, '0, '0);

    // Asynchronous reset during FLUSH
    ra = rnd163(); rb = rnd163();
    a_in = ra; b_in = rb; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NDIG) tick();
    chk("flush_busy", SRW'({busy, acc_en}), SRW'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_done", SRW'({busy, done, acc_en, acc_clr}), '0);
    chk("arst_digit", SRW'(b_digit_out), '0);
    chk("arst_a_out", SRW'(a_out), '0);
    chk("arst_result", SRW'(result_out), '0);
    tick();
    rst_n = 1'b1;
    n_done = 0;
    for (int cyc = 0; cyc < LAT + 5; cyc++) begin
      if (done || busy) n_done++;
      tick();
    end
    chk("arst_no_done", SRW'(n_done), '0);
    do_mul(ra, rb, "post_rst", 0, '0, '0);

    // Random operands
    for (int k = 0; k < 6; k++) begin
      do_mul(rnd163(), rnd163(), "rand", 0, '0, '0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
